// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold the full word length n, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: loads an n-bit word on a valid/ready handshake
// and shifts it out LSB-first, one bit per CLK edge with EN high; back-to-back words need no gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   n        = 4,
  parameter logic IDLE_OUT = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [n-1:0] D,
  input  logic         LOAD_VALID,
  output logic         LOAD_READY,
  input  logic         EN,
  output logic         OUT,
  output logic         OUT_VALID,
  output logic         DONE,
  output logic         BUSY
);

  localparam int CW = cnt_width(n);

  state_t         state;
  logic [n-1:0]   sreg;
  logic [CW-1:0]  cnt;
  logic           done_q;
  logic           last;

  assign last = (cnt == CW'(1));

  // The last-bit edge doubles as a load slot, so the only EN-to-output path is here.
  assign LOAD_READY = (state == IDLE) || (last && EN);
  assign OUT        = (state == SHIFT) ? sreg[0] : IDLE_OUT;
  assign OUT_VALID  = (state == SHIFT);
  assign BUSY       = (state == SHIFT);
  assign DONE       = done_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (LOAD_VALID) begin
            sreg  <= D;
            cnt   <= CW'(n);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (EN) begin
            sreg <= {1'b0, sreg[n-1:1]};
            cnt  <= cnt - CW'(1);
            if (last) begin
              done_q <= 1'b1;
              if (LOAD_VALID) begin
                sreg <= D;
                cnt  <= CW'(n);
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the lab datapath.
- Accepts an n-bit word through a valid/ready load handshake.
- Shifts the word out LSB-first, one bit per CLK edge on which EN is high.
- Bit order and EN qualification match the team's serial-in/parallel-out receiver. With both blocks driven by the same EN, the receiver's Q equals the loaded word after n enabled cycles.

Parameters:
- n, 4, word width in bits. Must be ≥ 2.
- IDLE_OUT, 1'b0, level driven on OUT when no word is being shifted.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- D  input  n  parallel word to transmit
- LOAD_VALID  input  1  D is valid and requests a load
- LOAD_READY  output  1  block can accept D this cycle
- EN  input  1  bit-time enable; one bit advances per CLK edge with EN=1
- OUT  output  1  serial data
- OUT_VALID  output  1  OUT carries a data bit
- DONE  output  1  one-cycle pulse after the last bit of a word is consumed
- BUSY  output  1  high while in SHIFT state

Behaviour:
- Reset (RST_N=0, asynchronous, no clock required):
  - state=IDLE, sreg=0, cnt=0, DONE=0.
  - OUT=IDLE_OUT, OUT_VALID=0, BUSY=0, LOAD_READY=1.
  - Reset may hit mid-word; the partial word is discarded with no DONE.
- States: IDLE, SHIFT. State is registered; LOAD_READY, OUT, OUT_VALID and BUSY are combinational from registers plus EN.
- IDLE:
  - LOAD_READY=1.
  - On an edge with LOAD_VALID=1: sreg←D, cnt←n, go to SHIFT. EN is ignored in IDLE.
- SHIFT outputs: OUT=sreg[0], OUT_VALID=1, BUSY=1.
- SHIFT, edge with EN=1:
  - sreg←{1'b0, sreg[n-1:1]}, cnt←cnt-1.
  - If cnt==1, this bit is the last one:
    - DONE=1 for the next cycle.
    - If LOAD_VALID=1 as well: sreg←D, cnt←n, stay in SHIFT (zero-gap back-to-back).
    - Otherwise go to IDLE.
- SHIFT, edge with EN=0: hold everything; OUT is stable.
- LOAD_READY in SHIFT = (cnt==1) && EN. This is the only combinational path from EN.
- LOAD_VALID while LOAD_READY=0: ignored, with no side effects. The upstream must hold D and LOAD_VALID until the handshake completes.
- DONE is registered, high for exactly one CLK cycle per completed word, and never asserted for aborted words.
- Latency:
  - The first bit appears on OUT the cycle after load.
  - A word occupies exactly n EN-qualified edges.
- cnt width is $clog2(n+1). cnt never underflows: it is 0 only in IDLE.
- D is sampled only on a load edge; changes to D at other times have no effect.

Decomposition:
- Package piso_pkg holds:
  - the state enum (IDLE=1'b0, SHIFT=1'b1);
  - a localparam function computing the counter width from n.
- The bit counter may optionally be a sub-module, bit_down_counter (load, decrement-on-enable, is_one flag).
- The rest stays in one flat module.

Test Plan:
- Reset/idle: assert RST_N=0 mid-cycle (asynchronous) → OUT=0, OUT_VALID=0, DONE=0, BUSY=0, LOAD_READY=1 immediately, without waiting for a CLK edge.
- Single word, EN=1 continuously:
  - Load D=4'b1011 → OUT sequence 1,1,0,1 on the 4 following cycles.
  - DONE pulses once, in the cycle after the 4th bit; then IDLE.
  - A receiver fed OUT with the same EN ends with Q=4'b1011.
- Gapped EN:
  - Load D=4'b0110 with EN pattern 1,0,0,1,1,0,1 → OUT holds during the EN=0 cycles.
  - Emitted bits are 0,1,1,0; DONE occurs after the 7th cycle.
- Back-to-back: D=4'b1001, then D=4'b0011 with LOAD_VALID held → 8 contiguous bits 1,0,0,1,1,1,0,0, OUT_VALID never drops, DONE pulses twice.
- Backpressure: assert LOAD_VALID with D=4'b1111 while mid-word (cnt=3) → LOAD_READY=0 and the current word is unaffected. The new word loads only on the last-bit edge.
- Reset mid-word: RST_N low after 2 bits of 4'b1010 → BUSY=0, no DONE. A fresh load of 4'b0101 then emits 1,0,1,0 correctly.
